uart_rx_fifo: RTL and testbench

- Downstream consumer of the UART byte receiver. Sees its level-type `rdy` flag and latches its 8-bit `data`.
- Acknowledges each byte by pulsing the receiver's `rdy_clr` input for one cycle.
- Buffers received bytes in a first-word-fall-through FIFO, so the UART loses no bytes while the downstream logic is busy.
- Presents bytes to the downstream logic on a valid/ready interface, with fill-level and sticky overflow status.

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer for the UART byte receiver: captures each byte flagged by rx_rdy,
// acknowledges it with a one-cycle rx_rdy_clr pulse and queues it in a first-word-fall-through FIFO.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_50m,
    input  logic                  rst,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  rx_rdy_clr,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_t;

    cap_state_t cap_state;
    cap_state_t cap_state_nxt;
    logic       wr_attempt;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  pop;
    logic                  wr_accept;
    logic                  wr_drop;

    // Capture FSM: the ACK cycle masks the still-high rx_rdy so each byte is taken once.
    always_comb begin
        cap_state_nxt = cap_state;
        wr_attempt    = 1'b0;
        case (cap_state)
            CAP_IDLE: begin
                if (rx_rdy) begin
                    wr_attempt    = 1'b1;
                    cap_state_nxt = CAP_ACK;
                end
            end
            CAP_ACK: begin
                cap_state_nxt = CAP_IDLE;
            end
            default: begin
                cap_state_nxt = CAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            cap_state <= CAP_IDLE;
        end else begin
            cap_state <= cap_state_nxt;
        end
    end

    // Decoded straight from the state register, so there is no path from rx_rdy.
    assign rx_rdy_clr = (cap_state == CAP_ACK);

    // Downstream handshake: a byte transfers on any cycle where out_valid and out_ready
    // are both high; out_data is stable and out_valid never drops until that happens.
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    assign pop       = out_valid && out_ready;
    assign wr_accept = wr_attempt && (!full || pop);
    assign wr_drop   = wr_attempt && !wr_accept;

    always_ff @(posedge clk_50m) begin
        if (wr_accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random byte traffic against a queue-based model
// of the receiver handshake and the 16-entry buffer.
module tb_uart_rx_fifo;

    logic       clk_50m;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy_clr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       ovf_clr;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    bit         m_ovf   = 1'b0;
    bit         ack_due = 1'b0;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_50m    (clk_50m),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    // clock / reset
    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state();
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        check("count", {27'd0, count}, exp_q.size());
        check("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
        check("full", {31'd0, full}, {31'd0, exp_q.size() == 16});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("rx_rdy_clr", {31'd0, rx_rdy_clr}, {31'd0, ack_due});
        if (exp_q.size() != 0) check("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
    endtask

    // One clock: drive inputs at the falling edge, advance the model, compare at the next falling edge.
    task automatic cycle(input logic rdy, input logic [7:0] d, input logic ordy, input logic clr);
        bit cap;
        bit pop;
        bit drop;
        rx_rdy    = rdy;
        rx_data   = d;
        out_ready = ordy;
        ovf_clr   = clr;
        cap  = rdy && !ack_due;
        pop  = (exp_q.size() != 0) && ordy;
        drop = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (cap) begin
            if (exp_q.size() < 16) exp_q.push_back(d);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        ack_due = cap;
        @(posedge clk_50m);
        @(negedge clk_50m);
        check_state();
    endtask

    // Receiver holds rdy through the acknowledge cycle and drops it at the edge ending it.
    task automatic send_byte(input logic [7:0] d, input logic o1, input logic o2);
        cycle(1'b1, d, o1, 1'b0);
        cycle(1'b1, d, o2, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 8'($urandom_range(0, 255)), ordy, 1'b0);
    endtask

    task automatic drain_expect(input logic [7:0] first_v, input int n);
        for (int i = 0; i < n; i++) begin
            check("drain_data", {24'd0, out_data}, {24'd0, 8'(first_v + 8'(i))});
            idle(1'b1);
        end
    endtask

    initial begin
        rst       = 1'b0;
        rx_rdy    = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk_50m);
        check_state();
        rst = 1'b1;

        // single byte, no double capture
        send_byte(8'hA5, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("a5_data", {24'd0, out_data}, 32'hA5);
        check("a5_count", {27'd0, count}, 32'd1);
        idle(1'b1);

        // fill, overflow, drain in order
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_ovf", {31'd0, overflow}, 32'd1);
        drain_expect(8'h00, 16);
        check("drain_empty", {31'd0, empty}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // write coincident with a pop while full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + 8'(i)), 1'b0, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b0);
        check("fullpop_count", {27'd0, count}, 32'd16);
        check("fullpop_ovf", {31'd0, overflow}, 32'd0);
        drain_expect(8'h11, 15);
        check("fullpop_last", {24'd0, out_data}, 32'h5A);
        idle(1'b1);

        // pass-through on an empty FIFO with out_ready held
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        check("pass_valid", {31'd0, out_valid}, 32'd1);
        check("pass_data", {24'd0, out_data}, 32'h3C);
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        check("pass_empty", {31'd0, empty}, 32'd1);

        // random traffic, pointers wrap several times
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) != 0)
                send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                cycle(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end
        while (exp_q.size() != 0) idle(1'b1);

        // drop and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        check("ovf_set_wins", {31'd0, overflow}, 32'd1);
        while (exp_q.size() != 0) idle(1'b1);

        // asynchronous reset during the acknowledge cycle with five bytes stored
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + 8'(i)), 1'b0, 1'b0);
        cycle(1'b1, 8'hC4, 1'b0, 1'b0);
        check("pre_rst_count", {27'd0, count}, 32'd5);
        #3 rst = 1'b0;
        #1;
        exp_q.delete();
        m_ovf   = 1'b0;
        ack_due = 1'b0;
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_rdy_clr", {31'd0, rx_rdy_clr}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk_50m);
        rst = 1'b1;
        send_byte(8'hC4, 1'b0, 1'b0);
        check("recapture_count", {27'd0, count}, 32'd1);
        check("recapture_data", {24'd0, out_data}, 32'hC4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
